// File: rtl/jesd204b_dl_rx_sync.sv
// jesd204b_dl_rx_sync: receive-side link establishment for one JESD204B lane.
// Runs code group synchronisation, checks and captures the ILAS, then forwards
// user data and monitors for control-character errors, requesting resync via sync_n.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   LMFC         one-cycle local multiframe boundary pulse
//   in_valid     qualifies in/in_charisk; low holds all state
//   in           32-bit lane word, octet 0 in [7:0] is first in time
//   in_charisk   per-octet control-character flags
//   out          registered user data (0 outside DATA)
//   out_valid    out carries user data
//   sync_n       SYNC~ to the transmitter, 0 = sync request
//   cfg_out      14 captured ILAS configuration octets, octet n at [8n+7:8n]
//   cfg_valid    cfg_out came from a clean ILAS
//   state        0=CGS, 1=CGS_WAIT, 2=ILAS, 3=DATA
//   error_count  saturating count of resync events
module jesd204b_dl_rx_sync #(
    parameter int unsigned OCTETS_PER_FR = 2,
    parameter int unsigned FRAMES_PER_MF = 10,
    parameter int unsigned CGS_WORDS     = 4,
    parameter int unsigned ERR_THRESH    = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         LMFC,
    input  logic         in_valid,
    input  logic [31:0]  in,
    input  logic [3:0]   in_charisk,
    output logic [31:0]  out,
    output logic         out_valid,
    output logic         sync_n,
    output logic [111:0] cfg_out,
    output logic         cfg_valid,
    output logic [1:0]   state,
    output logic [7:0]   error_count
);

    localparam int unsigned MF_WORDS = (OCTETS_PER_FR * FRAMES_PER_MF) / 4;
    localparam int unsigned WW       = $clog2(MF_WORDS);

    localparam logic [1:0] S_CGS      = 2'd0;
    localparam logic [1:0] S_CGS_WAIT = 2'd1;
    localparam logic [1:0] S_ILAS     = 2'd2;
    localparam logic [1:0] S_DATA     = 2'd3;

    localparam logic [7:0] SYM_K = 8'hBC;
    localparam logic [7:0] SYM_R = 8'h1C;
    localparam logic [7:0] SYM_A = 8'h7C;
    localparam logic [7:0] SYM_Q = 8'h9C;
    localparam logic [7:0] SYM_F = 8'hFC;

    localparam logic [WW-1:0] W_LAST = WW'(MF_WORDS - 1);

    logic [3:0]    k_cnt, k_cnt_d;
    logic [WW-1:0] word_idx, word_d;
    logic [1:0]    mf_idx, mf_d;
    logic [3:0]    err_cnt, err_cnt_d;

    logic [1:0]    state_d;
    logic [31:0]   out_d;
    logic          out_valid_d, sync_n_d, cfg_valid_d;
    logic [111:0]  cfg_d;
    logic [7:0]    error_count_d;

    // Word classification
    logic [3:0]    is_k_oct;
    logic [2:0]    word_errs;
    logic          k_word, oct0_r, oct0_q, oct3_a;
    logic [3:0]    k_cnt_inc;
    logic          k_lock;
    logic          word_last;
    logic [WW-1:0] word_idx_inc;
    logic [3:0]    err_base;
    logic [4:0]    err_sum;
    logic          err_hit;

    always_comb begin
        is_k_oct  = '0;
        word_errs = '0;
        for (int n = 0; n < 4; n++) begin
            is_k_oct[n] = in_charisk[n] && (in[8*n +: 8] == SYM_K);
            if (in_charisk[n] && (in[8*n +: 8] != SYM_F) && (in[8*n +: 8] != SYM_A)) begin
                word_errs = word_errs + 3'd1;
            end
        end
    end

    assign k_word       = &is_k_oct;
    assign oct0_r       = in_charisk[0] && (in[7:0]   == SYM_R);
    assign oct0_q       = in_charisk[0] && (in[7:0]   == SYM_Q);
    assign oct3_a       = in_charisk[3] && (in[31:24] == SYM_A);
    assign k_cnt_inc    = (k_cnt == 4'hF) ? k_cnt : k_cnt + 4'd1;
    assign k_lock       = k_cnt_inc >= 4'(CGS_WORDS);
    assign word_last    = word_idx == W_LAST;
    assign word_idx_inc = word_last ? '0 : word_idx + WW'(1);
    // Per-multiframe error tally restarts on the first word of each multiframe
    assign err_base     = (word_idx == '0) ? 4'd0 : err_cnt;
    assign err_sum      = {1'b0, err_base} + 5'(word_errs);
    assign err_hit      = err_sum >= 5'(ERR_THRESH);

    // Next-state and output logic
    always_comb begin
        logic resync;
        state_d       = state;
        out_d         = out;
        out_valid_d   = out_valid;
        sync_n_d      = sync_n;
        cfg_d         = cfg_out;
        cfg_valid_d   = cfg_valid;
        error_count_d = error_count;
        k_cnt_d       = k_cnt;
        word_d        = word_idx;
        mf_d          = mf_idx;
        err_cnt_d     = err_cnt;
        resync        = 1'b0;

        if (in_valid) begin
            case (state)
                S_CGS: begin
                    if (k_word) begin
                        k_cnt_d = k_cnt_inc;
                        if (k_lock && LMFC) begin
                            state_d  = S_CGS_WAIT;
                            sync_n_d = 1'b1;
                            k_cnt_d  = '0;
                        end
                    end else begin
                        k_cnt_d = '0;
                    end
                end
                S_CGS_WAIT: begin
                    if (!k_word) begin
                        if (oct0_r) begin
                            state_d = S_ILAS;
                            word_d  = WW'(1);
                            mf_d    = 2'd0;
                        end else begin
                            resync = 1'b1;
                        end
                    end
                end
                S_ILAS: begin
                    if ((word_idx == '0) && !oct0_r) resync = 1'b1;
                    if (word_last && !oct3_a) resync = 1'b1;
                    if ((mf_idx == 2'd1) && (word_idx == WW'(1)) && !oct0_q) resync = 1'b1;
                    // Config octets occupy byte offsets 5..18 of the second multiframe
                    if (mf_idx == 2'd1) begin
                        if (word_idx == WW'(1))      cfg_d[23:0]   = in[31:8];
                        else if (word_idx == WW'(2)) cfg_d[55:24]  = in;
                        else if (word_idx == WW'(3)) cfg_d[87:56]  = in;
                        else if (word_idx == WW'(4)) cfg_d[111:88] = in[23:0];
                    end
                    word_d = word_idx_inc;
                    if (word_last) begin
                        mf_d = mf_idx + 2'd1;
                        if (mf_idx == 2'd3) begin
                            state_d     = S_DATA;
                            cfg_valid_d = 1'b1;
                        end
                    end
                end
                default: begin
                    out_d       = in;
                    out_valid_d = 1'b1;
                    word_d      = word_idx_inc;
                    err_cnt_d   = err_sum[3:0];
                    k_cnt_d     = k_word ? k_cnt_inc : 4'd0;
                    if (err_hit || (k_word && k_lock)) resync = 1'b1;
                end
            endcase

            if (resync) begin
                state_d     = S_CGS;
                sync_n_d    = 1'b0;
                cfg_valid_d = 1'b0;
                out_d       = '0;
                out_valid_d = 1'b0;
                k_cnt_d     = '0;
                word_d      = '0;
                mf_d        = '0;
                err_cnt_d   = '0;
                if (error_count != 8'hFF) error_count_d = error_count + 8'd1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_CGS;
            out         <= '0;
            out_valid   <= 1'b0;
            sync_n      <= 1'b0;
            cfg_out     <= '0;
            cfg_valid   <= 1'b0;
            error_count <= '0;
            k_cnt       <= '0;
            word_idx    <= '0;
            mf_idx      <= '0;
            err_cnt     <= '0;
        end else begin
            state       <= state_d;
            out         <= out_d;
            out_valid   <= out_valid_d;
            sync_n      <= sync_n_d;
            cfg_out     <= cfg_d;
            cfg_valid   <= cfg_valid_d;
            error_count <= error_count_d;
            k_cnt       <= k_cnt_d;
            word_idx    <= word_d;
            mf_idx      <= mf_d;
            err_cnt     <= err_cnt_d;
        end
    end

endmodule
